// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and default datapath width for the alu.
package alu_pkg;
  localparam int ALU_WIDTH = 16;
  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_LSH   = 8'h04;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_ADDU  = 8'h06;
  localparam logic [7:0] OP_ADDCU = 8'h07;
  localparam logic [7:0] OP_SUB   = 8'h09;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_MOV   = 8'h0D;
  localparam logic [7:0] OP_MUL   = 8'h0E;
  localparam logic [7:0] OP_NOT   = 8'h0F;
  localparam logic [7:0] OP_ADDI  = 8'h50;
  localparam logic [7:0] OP_ADDUI = 8'h60;
  localparam logic [7:0] OP_ADDCUI = 8'h70;
  localparam logic [7:0] OP_SUBI  = 8'h90;
  localparam logic [7:0] OP_CMPI  = 8'hB0;
  function automatic logic is_sub_op(input logic [7:0] op);
    return op inside {OP_SUB, OP_SUBI, OP_CMP, OP_CMPI};
  endfunction
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational adder/subtractor shared by ADD*, SUB* and CMP.
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH:0]   sum,
  output logic             overflow,
  output logic             carry
);
  logic [WIDTH-1:0] bx;
  // subtraction is a + ~b + 1, so the carry-in slot is forced high
  assign bx = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub | cin};
  assign carry = sum[WIDTH];
  assign overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu.sv
// alu: registered 16-bit integer ALU with status flags.
// Define ALU_MUL_EN to build the signed multiplier for opcode MUL.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [7:0]       Opcode,
  input  logic             CarryIn,
  output logic [WIDTH-1:0] C,
  output logic             Carry,
  output logic             Flag,
  output logic             Low,
  output logic             Negative,
  output logic             Zero
);
  logic [WIDTH:0] s;
  logic ovf, cy, cin, nz;
  logic [WIDTH-1:0] c;
  logic carry, flag, low, neg, zero;
  logic [4:0] mag;
  assign cin = (Opcode == OP_ADDCU || Opcode == OP_ADDCUI) && CarryIn;
  // LSH amount is a signed 5-bit field; negative values shift right
  assign mag = B[4] ? -B[4:0] : B[4:0];
  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(A),
    .b(B),
    .sub(is_sub_op(Opcode)),
    .cin(cin),
    .sum(s),
    .overflow(ovf),
    .carry(cy)
  );
`ifdef ALU_MUL_EN
  logic signed [2*WIDTH-1:0] prod;
  assign prod = $signed(A) * $signed(B);
`endif
  always_comb begin
    c = '0;
    carry = 1'b0;
    flag = 1'b0;
    low = 1'b0;
    neg = 1'b0;
    zero = 1'b0;
    nz = 1'b1;
    case (Opcode)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
        c = s[WIDTH-1:0];
        flag = ovf;
      end
      OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
        c = s[WIDTH-1:0];
        carry = s[WIDTH];
      end
      OP_CMP, OP_CMPI: begin
        nz = 1'b0;
        zero = A == B;
        low = ~cy;
        neg = s[WIDTH-1] ^ ovf;
      end
      OP_AND: c = A & B;
      OP_OR:  c = A | B;
      OP_XOR: c = A ^ B;
      OP_NOT: c = ~A;
      OP_MOV: c = B;
      OP_LSH: c = B[4] ? A >> mag : A << mag;
`ifdef ALU_MUL_EN
      OP_MUL: begin
        c = prod[WIDTH-1:0];
        flag = prod != {{WIDTH{prod[WIDTH-1]}}, prod[WIDTH-1:0]};
      end
`endif
      default: nz = 1'b0;
    endcase
    if (nz) begin
      neg = c[WIDTH-1];
      zero = ~|c;
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      C <= '0;
      Carry <= 1'b0;
      Flag <= 1'b0;
      Low <= 1'b0;
      Negative <= 1'b0;
      Zero <= 1'b0;
    end else begin
      C <= c;
      Carry <= carry;
      Flag <= flag;
      Low <= low;
      Negative <= neg;
      Zero <= zero;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors for alu, checked every cycle against an arithmetic model.
module tb_alu;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [15:0] A = 16'h0;
  logic [15:0] B = 16'h0;
  logic [7:0] Opcode = 8'h0;
  logic CarryIn = 1'b0;
  logic [15:0] C;
  logic Carry, Flag, Low, Negative, Zero;
  int checks = 0;
  int fails = 0;
  alu dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .A(A),
    .B(B),
    .Opcode(Opcode),
    .CarryIn(CarryIn),
    .C(C),
    .Carry(Carry),
    .Flag(Flag),
    .Low(Low),
    .Negative(Negative),
    .Zero(Zero)
  );
  always #5 Clk = ~Clk;
  // returns {C, Carry, Flag, Low, Negative, Zero}
  function automatic logic [20:0] model(input logic rn, input logic [7:0] op,
                                        input logic [15:0] a, input logic [15:0] b, input logic ci);
    int sa, sb, ua, ub, r, amt;
    logic signed [4:0] sh;
    logic [15:0] c;
    logic cy, fl, lo, ng, zr, nz;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    c = 16'h0;
    cy = 0; fl = 0; lo = 0; ng = 0; zr = 0; nz = 1;
    case (op)
      8'h05, 8'h50: begin r = sa + sb; c = r[15:0]; fl = r > 32767 || r < -32768; end
      8'h09, 8'h90: begin r = sa - sb; c = r[15:0]; fl = r > 32767 || r < -32768; end
      8'h06, 8'h60: begin r = ua + ub; c = r[15:0]; cy = r > 65535; end
      8'h07, 8'h70: begin r = ua + ub + (ci ? 1 : 0); c = r[15:0]; cy = r > 65535; end
      8'h0B, 8'hB0: begin nz = 0; lo = ua < ub; ng = sa < sb; zr = ua == ub; end
      8'h01: c = a & b;
      8'h02: c = a | b;
      8'h03: c = a ^ b;
      8'h0F: c = ~a;
      8'h0D: c = b;
      8'h04: begin
        sh = b[4:0];
        amt = sh;
        r = amt >= 0 ? ua << amt : ua >> (-amt);
        c = r[15:0];
      end
`ifdef ALU_MUL_EN
      8'h0E: begin r = sa * sb; c = r[15:0]; fl = r > 32767 || r < -32768; end
`endif
      default: nz = 0;
    endcase
    if (nz) begin ng = c[15]; zr = c == 16'h0; end
    return rn ? {c, cy, fl, lo, ng, zr} : 21'h0;
  endfunction
  logic [20:0] exp_q, lit_vn, lit_vq, act;
  logic exp_v = 1'b0;
  logic lit_n = 1'b0;
  logic lit_q = 1'b0;
  string nm_n = "";
  string nm_q = "";
  assign act = {C, Carry, Flag, Low, Negative, Zero};
  always @(posedge Clk) begin
    exp_q <= model(Reset_n, Opcode, A, B, CarryIn);
    exp_v <= 1'b1;
    lit_q <= lit_n;
    lit_vq <= lit_vn;
    nm_q <= nm_n;
  end
  always @(negedge Clk) begin
    if (exp_v) begin
      checks++;
      if (act !== exp_q) begin
        fails++;
        $display("FAIL model t=%0t got C=%h flags=%b want C=%h flags=%b", $time, act[20:5], act[4:0], exp_q[20:5], exp_q[4:0]);
      end
      if (lit_q) begin
        checks += 2;
        if (act !== lit_vq) begin
          fails++;
          $display("FAIL %s got C=%h flags=%b want C=%h flags=%b", nm_q, act[20:5], act[4:0], lit_vq[20:5], lit_vq[4:0]);
        end
        if (exp_q !== lit_vq) begin
          fails++;
          $display("FAIL pin_%s model C=%h flags=%b want C=%h flags=%b", nm_q, exp_q[20:5], exp_q[4:0], lit_vq[20:5], lit_vq[4:0]);
        end
      end
    end
  end
  task automatic vec(input string n, input logic rn, input logic [7:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic ci, input logic [15:0] c, input logic [4:0] f);
    @(negedge Clk);
    Reset_n = rn;
    Opcode = op;
    A = a;
    B = b;
    CarryIn = ci;
    lit_n = 1'b1;
    nm_n = n;
    lit_vn = {c, f};
  endtask
  initial begin
    Opcode = 8'h05; A = 16'hABCD; B = 16'h1234; CarryIn = 1'b1;
    vec("reset0", 0, 8'h05, 16'h7FFF, 16'h0001, 1, 16'h0000, 5'b00000);
    vec("reset1", 0, 8'h06, 16'hFFFF, 16'h0001, 1, 16'h0000, 5'b00000);
    vec("add_ovf", 1, 8'h05, 16'h7FFF, 16'h0001, 0, 16'h8000, 5'b01010);
    vec("add_neg_a", 1, 8'h50, 16'hFFF1, 16'd42, 1, 16'h001B, 5'b00000);
    vec("addu_carry", 1, 8'h06, 16'hFFFF, 16'h0001, 0, 16'h0000, 5'b10001);
    vec("addcu_cin", 1, 8'h07, 16'hFFFF, 16'h0000, 1, 16'h0000, 5'b10001);
    vec("addcui_nocin", 1, 8'h70, 16'h1000, 16'h0234, 0, 16'h1234, 5'b00000);
    vec("addu_cin_ignored", 1, 8'h60, 16'h0001, 16'h0001, 1, 16'h0002, 5'b00000);
    vec("sub_neg", 1, 8'h09, 16'd45, 16'd47, 0, 16'hFFFE, 5'b00010);
    vec("sub_ovf", 1, 8'h90, 16'h8000, 16'h0001, 0, 16'h7FFF, 5'b01000);
    vec("sub_ovf_pos", 1, 8'h09, 16'h7FFF, 16'hFFFF, 0, 16'h8000, 5'b01010);
    vec("cmp_lt_u", 1, 8'h0B, 16'h0001, 16'hFFFF, 0, 16'h0000, 5'b00100);
    vec("cmp_eq", 1, 8'hB0, 16'h1234, 16'h1234, 0, 16'h0000, 5'b00001);
    vec("cmp_lt_s", 1, 8'h0B, 16'h8000, 16'h0001, 0, 16'h0000, 5'b00010);
    vec("and", 1, 8'h01, 16'hF0F0, 16'h0FF0, 0, 16'h00F0, 5'b00000);
    vec("lsh_right1", 1, 8'h04, 16'h8001, 16'h001F, 0, 16'h4000, 5'b00000);
    vec("lsh_left3", 1, 8'h04, 16'h0011, 16'h0003, 0, 16'h0088, 5'b00000);
    vec("lsh_right15", 1, 8'h04, 16'h8000, 16'h0011, 0, 16'h0001, 5'b00000);
    vec("lsh_left15", 1, 8'h04, 16'h0003, 16'h000F, 0, 16'h8000, 5'b00010);
    vec("or", 1, 8'h02, 16'h0F00, 16'h8001, 0, 16'h8F01, 5'b00010);
    vec("xor_zero", 1, 8'h03, 16'h5A5A, 16'h5A5A, 0, 16'h0000, 5'b00001);
    vec("not", 1, 8'h0F, 16'h0000, 16'h1234, 0, 16'hFFFF, 5'b00010);
    vec("mov", 1, 8'h0D, 16'hFFFF, 16'h0000, 0, 16'h0000, 5'b00001);
    vec("illegal", 1, 8'hFF, 16'h1234, 16'h5678, 1, 16'h0000, 5'b00000);
`ifdef ALU_MUL_EN
    vec("mul_ovf", 1, 8'h0E, 16'h0100, 16'h0100, 0, 16'h0000, 5'b01001);
    vec("mul_neg", 1, 8'h0E, 16'hFFFE, 16'h0003, 0, 16'hFFFA, 5'b00010);
`else
    vec("mul_illegal", 1, 8'h0E, 16'h0100, 16'h0100, 0, 16'h0000, 5'b00000);
    vec("mul_illegal2", 1, 8'h0E, 16'hFFFE, 16'h0003, 0, 16'h0000, 5'b00000);
`endif
    vec("reset_mid", 0, 8'h0F, 16'h0000, 16'h0000, 0, 16'h0000, 5'b00000);
    vec("after_reset", 1, 8'h0D, 16'h0000, 16'h8000, 0, 16'h8000, 5'b00010);
    @(negedge Clk);
    lit_n = 1'b0;
    Opcode = 8'h00;
    @(negedge Clk);
    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
